apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 141 ++++++++++++++
 tb/tb_apb_master.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Brief    : Single-outstanding command/response to APB master bridge with
//            optional PREADY timeout.
// Revision : 1.0
// ============================================================================
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PSELx,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // A zero timeout still needs a one-bit counter to keep the widths legal.
    localparam int            C_CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [C_CW-1:0] C_TMO = C_CW'(TIMEOUT_CYCLES);
    localparam logic [C_CW-1:0] C_MAX = {C_CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    logic [C_CW-1:0]       r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic w_cmd_ready;
    logic w_timeout;

    assign w_cmd_ready = (r_state == ST_IDLE) && !r_rsp_valid;
    assign w_timeout   = (TIMEOUT_CYCLES > 0) && (r_wait_cnt == C_TMO);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            // Consumption only happens in IDLE, so it never collides with the
            // response being raised from ACCESS below.
            if (r_rsp_valid && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_ready && i_cmd_valid) begin
                        r_paddr    <= i_cmd_addr;
                        r_pwrite   <= i_cmd_write;
                        r_pwdata   <= i_cmd_wdata;
                        r_psel     <= 1'b1;
                        r_penable  <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
                        r_state       <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_state       <= ST_IDLE;
                    end else if (r_wait_cnt != C_MAX) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready   = w_cmd_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;
    assign PADDR         = r_paddr;
    assign PWRITE        = r_pwrite;
    assign PWDATA        = r_pwdata;
    assign PSELx         = r_psel;
    assign PENABLE       = r_penable;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Brief    : Directed and randomized transfers against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_apb_master;

    localparam int C_AW  = 32;
    localparam int C_DW  = 32;
    localparam int C_TMO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [C_AW-1:0] cmd_addr;
    logic [C_DW-1:0] cmd_wdata;
    logic            rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [C_DW-1:0] rsp_rdata;
    logic [C_AW-1:0] paddr;
    logic            pwrite, psel, penable, pready, pslverr;
    logic [C_DW-1:0] pwdata, prdata;

    int checks = 0;
    int errors = 0;

    apb_master #(
        .ADDR_WIDTH    (C_AW),
        .DATA_WIDTH    (C_DW),
        .TIMEOUT_CYCLES(C_TMO)
    ) u_dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_write  (cmd_write),
        .i_cmd_addr   (cmd_addr),
        .i_cmd_wdata  (cmd_wdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_rsp_timeout(rsp_timeout),
        .PADDR        (paddr),
        .PWRITE       (pwrite),
        .PWDATA       (pwdata),
        .PSELx        (psel),
        .PENABLE      (penable),
        .PRDATA       (prdata),
        .PREADY       (pready),
        .PSLVERR      (pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer. The model works at transaction level: the slave answers
    // after n_wait wait states unless that exceeds the timeout budget, in which
    // case the bridge gives up after C_TMO+1 ACCESS cycles.
    task automatic run_xfer(input logic w, input logic [C_AW-1:0] a, input logic [C_DW-1:0] d,
                            input int n_wait, input logic [C_DW-1:0] rd, input logic err,
                            input int rsp_hold);
        bit              exp_to;
        int              exp_access;
        logic [C_DW-1:0] exp_rdata;
        logic            exp_err;
        exp_to     = (n_wait > C_TMO);
        exp_access = exp_to ? C_TMO + 1 : n_wait + 1;
        exp_err    = exp_to ? 1'b1 : err;
        exp_rdata  = (exp_to || w) ? '0 : rd;

        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom;
        // Slave noise outside ACCESS must not complete the transfer early.
        pready = 1; pslverr = 1; prdata = $urandom;
        chk("setup_psel", {psel, penable}, 2'b10);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", pwrite, w);
        chk("setup_pwdata", pwdata, d);
        chk("setup_cmd_ready", cmd_ready, 0);
        tick();
        for (int i = 0; i < exp_access; i++) begin
            chk("access_psel", {psel, penable}, 2'b11);
            chk("access_paddr", paddr, a);
            chk("access_pwdata", {pwrite, pwdata}, {w, d});
            pready  = (i == n_wait);
            pslverr = (i == n_wait) ? err : $urandom;
            prdata  = (i == n_wait) ? rd : $urandom;
            tick();
        end
        pready = 1; pslverr = 1; prdata = $urandom;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_apb_idle", {psel, penable}, 2'b00);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        for (int h = 0; h < rsp_hold; h++) begin
            cmd_valid = 1; rsp_ready = 0;
            tick();
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
                {1'b1, exp_err, exp_to, exp_rdata});
            chk("hold_psel", psel, 0);
        end
        cmd_valid = 1; rsp_ready = 1;
        tick();
        cmd_valid = 0; rsp_ready = 0;
        chk("consumed_rsp_valid", rsp_valid, 0);
        chk("consumed_no_accept", psel, 0);
        chk("consumed_cmd_ready", cmd_ready, 1);
        pready = 0; pslverr = 0;
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 0; pready = 0; pslverr = 0; prdata = '0;
        tick();
        tick();
        chk("reset_outputs", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}, 6'b0);
        chk("reset_paddr", paddr, 0);
        chk("reset_pwdata", pwdata, 0);
        chk("reset_rdata", rsp_rdata, 0);
        rst = 0;
        tick();
        chk("cmd_ready_after_reset", cmd_ready, 1);

        run_xfer(1'b1, 32'h4, 32'hDEADBEEF, 0, 32'hCAFEF00D, 1'b0, 0);
        run_xfer(1'b0, 32'h8, 32'h0, 3, 32'h12345678, 1'b0, 1);
        run_xfer(1'b0, 32'hC, 32'h0, 0, 32'hA5A5A5A5, 1'b1, 0);
        run_xfer(1'b0, 32'h10, 32'h0, 99, 32'h55AA55AA, 1'b0, 0);
        run_xfer(1'b1, 32'h14, 32'h1, C_TMO, 32'h77, 1'b1, 5);

        for (int t = 0; t < 24; t++) begin
            run_xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 7)),
                     $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a wait-stated ACCESS aborts with no response.
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
        tick();
        cmd_valid = 0; pready = 0;
        tick();
        tick();
        chk("pre_reset_access", {psel, penable}, 2'b11);
        rst = 1;
        tick();
        chk("reset_abort_apb", {psel, penable}, 2'b00);
        chk("reset_abort_rsp", rsp_valid, 0);
        rst = 0;
        tick();
        chk("reset_abort_ready", cmd_ready, 1);
        tick();
        chk("reset_abort_no_rsp", rsp_valid, 0);

        run_xfer(1'b0, 32'h24, 32'h0, 1, 32'h0BADF00D, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
